erasable_memory_responder: RTL and testbench

ERASABLE_MEMORY_RESPONDER -- requirements
Module: erasable_memory_responder

---
 rtl/erasable_memory_responder.sv | 164 ++++++++++++++++
 tb/tb_erasable_memory_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/erasable_memory_responder.sv
// erasable_memory_responder
//   Core-memory style erasable store: 2048 x 16 words, bank (3b) + offset (8b).
//   Every access is a destructive sense followed by a rewrite, so reads and
//   writes both walk IDLE -> SENSE -> REWRITE -> IDLE.
//
//   Optional feature macro: ERASABLE_PARITY_EN
//     defined   : bit 16 (MSB) is regenerated on write for odd parity; every
//                 sensed word of a read is checked and an even word sets PARALM.
//     undefined : bit 16 stored verbatim, PARALM tied low.
//
//   Parameter
//     SENSE_WAIT  extra SENSE cycles (0..7); SENSE lasts 1+SENSE_WAIT cycles
//   Ports
//     SIM_CLK   clock, rising edge
//     SIM_RST   async active-high reset (array is not cleared)
//     S[11:0]   S-register address S[12:1]; S[7:0] offset, S[9:8] bank,
//               S[11:10] must be zero (erasable range)
//     EB[2:0]   erasable bank, used when S[9:8] == 2'b11
//     RD_REQ    read request  (sampled in IDLE)
//     WR_REQ    write request (sampled in IDLE); both together = exchange
//     WDATA     write word, [15] parity, [14:0] data
//     RDATA     read word, held until the next RVALID
//     RVALID    one-cycle strobe qualifying RDATA
//     BUSY      high in SENSE and REWRITE
//     ADDRERR   one-cycle strobe for a non-erasable address
//     DROP      sticky: a request arrived while busy
//     PARALM    sticky parity alarm
module erasable_memory_responder #(
  parameter int SENSE_WAIT = 0
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic [11:0] S,
  input  logic [2:0]  EB,
  input  logic        RD_REQ,
  input  logic        WR_REQ,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        RVALID,
  output logic        BUSY,
  output logic        ADDRERR,
  output logic        DROP,
  output logic        PARALM
);

  typedef enum logic [1:0] {IDLE, SENSE, REWRITE} state_t;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [10:0] addr;
    logic [15:0] wdata;
  } req_t;

  localparam logic [2:0] SENSE_INIT = 3'(SENSE_WAIT);

  logic [15:0] mem [0:2047];

  state_t      state;
  logic [2:0]  cnt;
  req_t        req_q;
  logic [15:0] sense_q;    // word taken out of the core, restored on a read

  logic [2:0]  bank;
  logic [10:0] addr_in;
  logic        req_in;
  logic        addr_bad;
  logic [15:0] sense_word;
  logic [15:0] wr_word;
  logic        sense_even;

  // S[9:8] == 3 is the switched window; the other three banks are fixed.
  assign bank       = (S[9:8] == 2'b11) ? EB : {1'b0, S[9:8]};
  assign addr_in    = {bank, S[7:0]};
  assign req_in     = RD_REQ | WR_REQ;
  assign addr_bad   = |S[11:10];
  assign sense_word = mem[req_q.addr];
  assign sense_even = ~^sense_word;

`ifdef ERASABLE_PARITY_EN
  logic unused_wdata_par;
  assign unused_wdata_par = req_q.wdata[15];
  // Generated bit makes the whole 16-bit word hold an odd number of ones.
  assign wr_word = {~^req_q.wdata[14:0], req_q.wdata[14:0]};
`else
  logic unused_sense_even;
  assign unused_sense_even = sense_even;
  assign wr_word = req_q.wdata;
  assign PARALM  = 1'b0;
`endif

  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      req_q   <= '0;
      sense_q <= '0;
      RDATA   <= '0;
      RVALID  <= 1'b0;
      BUSY    <= 1'b0;
      ADDRERR <= 1'b0;
      DROP    <= 1'b0;
`ifdef ERASABLE_PARITY_EN
      PARALM  <= 1'b0;
`endif
    end else begin
      RVALID  <= 1'b0;
      ADDRERR <= 1'b0;
      case (state)
        IDLE: begin
          if (req_in) begin
            if (addr_bad) begin
              // Fixed-memory addresses never start a core cycle.
              ADDRERR <= 1'b1;
            end else begin
              req_q.rd    <= RD_REQ;
              req_q.wr    <= WR_REQ;
              req_q.addr  <= addr_in;
              req_q.wdata <= WDATA;
              cnt         <= SENSE_INIT;
              BUSY        <= 1'b1;
              state       <= SENSE;
            end
          end
        end
        SENSE: begin
          if (req_in) DROP <= 1'b1;
          if (cnt == 3'd0) begin
            // RVALID rises on the edge that ends SENSE: the second edge
            // counting the sampling edge, plus SENSE_WAIT.
            sense_q <= sense_word;
            state   <= REWRITE;
            if (req_q.rd) begin
              RDATA  <= sense_word;
              RVALID <= 1'b1;
`ifdef ERASABLE_PARITY_EN
              if (sense_even) PARALM <= 1'b1;
`endif
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        REWRITE: begin
          if (req_in) DROP <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The array only changes on the REWRITE -> IDLE edge, so a reset anywhere
  // earlier in the cycle leaves the addressed word intact.
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST && state == REWRITE)
      mem[req_q.addr] <= req_q.wr ? wr_word : sense_q;
  end

endmodule

// File: tb/tb_erasable_memory_responder.sv
// Directed bench for erasable_memory_responder. dut0 runs with SENSE_WAIT=0,
// dut3 with SENSE_WAIT=3; they share request inputs and each is held in
// reset while the other is exercised.
module tb_erasable_memory_responder;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1, rst3 = 1'b1;
  logic [11:0] s = '0;
  logic [2:0]  eb = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [15:0] wd = '0;

  logic [15:0] rdata0, rdata3;
  logic        rvalid0, busy0, adderr0, drop0, paralm0;
  logic        rvalid3, busy3, adderr3, drop3, paralm3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  erasable_memory_responder #(.SENSE_WAIT(0)) dut0 (
    .SIM_CLK(clk), .SIM_RST(rst0), .S(s), .EB(eb), .RD_REQ(rd), .WR_REQ(wr),
    .WDATA(wd), .RDATA(rdata0), .RVALID(rvalid0), .BUSY(busy0),
    .ADDRERR(adderr0), .DROP(drop0), .PARALM(paralm0));

  erasable_memory_responder #(.SENSE_WAIT(3)) dut3 (
    .SIM_CLK(clk), .SIM_RST(rst3), .S(s), .EB(eb), .RD_REQ(rd), .WR_REQ(wr),
    .WDATA(wd), .RDATA(rdata3), .RVALID(rvalid3), .BUSY(busy3),
    .ADDRERR(adderr3), .DROP(drop3), .PARALM(paralm3));

  // Stored forms of the words used below (odd parity regenerated when enabled).
`ifdef ERASABLE_PARITY_EN
  localparam logic [15:0] W3 = 16'o100003;
  localparam logic [15:0] W5 = 16'o100005;
`else
  localparam logic [15:0] W3 = 16'o000003;
  localparam logic [15:0] W5 = 16'o000005;
`endif
  localparam logic [15:0] W12345 = 16'o012345;  // 7 ones: unchanged
  localparam logic [15:0] W456   = 16'o000456;  // 5 ones: unchanged
  localparam logic [15:0] W1     = 16'o000001;
  localparam logic [15:0] W7     = 16'o000007;  // 3 ones: already odd

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %o expected %o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one sampling edge.
  task automatic issue(input logic r, input logic w, input logic [11:0] a,
                       input logic [2:0] b, input logic [15:0] d);
    rd = r; wr = w; s = a; eb = b; wd = d;
    tick();
    rd = 1'b0; wr = 1'b0;
  endtask

  // Full core cycle on the selected dut; returns what was seen right after
  // the SENSE -> REWRITE edge.
  task automatic op(input logic r, input logic w, input logic [11:0] a,
                    input logic [2:0] b, input logic [15:0] d, input int sw,
                    output logic [15:0] q, output logic v);
    issue(r, w, a, b, d);
    repeat (sw) tick();
    tick();
    q = (sw == 0) ? rdata0 : rdata3;
    v = (sw == 0) ? rvalid0 : rvalid3;
    tick();
  endtask

  logic [15:0] q;
  logic        v;

  initial begin
    // ---------------- dut0, SENSE_WAIT = 0 ----------------
    tick(); tick();
    chk("rst_rdata",   rdata0,  16'd0);
    chk("rst_rvalid",  16'(rvalid0), 16'd0);
    chk("rst_busy",    16'(busy0),   16'd0);
    chk("rst_addrerr", 16'(adderr0), 16'd0);
    chk("rst_drop",    16'(drop0),   16'd0);
    chk("rst_paralm",  16'(paralm0), 16'd0);
    rst0 = 1'b0;

    // Write on the first edge after reset release.
    issue(1'b0, 1'b1, 12'o0100, 3'd0, 16'o000003);
    chk("wr_busy_sense", 16'(busy0), 16'd1);
    tick();
    chk("wr_no_rvalid", 16'(rvalid0), 16'd0);
    chk("wr_rdata_hold", rdata0, 16'd0);
    chk("wr_busy_rewrite", 16'(busy0), 16'd1);
    tick();
    chk("wr_idle_busy", 16'(busy0), 16'd0);

    // Read back, latency checked edge by edge.
    issue(1'b1, 1'b0, 12'o0100, 3'd0, 16'd0);
    chk("rd_lat_edge1", 16'(rvalid0), 16'd0);
    tick();
    chk("rd_lat_edge2", 16'(rvalid0), 16'd1);
    chk("rd_data", rdata0, W3);
    chk("rd_paralm", 16'(paralm0), 16'd0);
    tick();
    chk("rd_strobe_end", 16'(rvalid0), 16'd0);
    chk("rd_data_held", rdata0, W3);

    // Banking through the switched window.
    op(1'b0, 1'b1, 12'o0000, 3'd0, 16'o000456, 0, q, v);
    op(1'b0, 1'b1, 12'o1400, 3'd5, 16'o012345, 0, q, v);
    op(1'b1, 1'b0, 12'o1400, 3'd5, 16'd0, 0, q, v);
    chk("bank5_data", q, W12345);
    op(1'b1, 1'b0, 12'o1400, 3'd0, 16'd0, 0, q, v);
    chk("bank0_window", q, W456);
    op(1'b1, 1'b0, 12'o0000, 3'd0, 16'd0, 0, q, v);
    chk("bank0_fixed", q, W456);

    // Exchange.
    op(1'b0, 1'b1, 12'o0200, 3'd0, 16'o000001, 0, q, v);
    op(1'b1, 1'b1, 12'o0200, 3'd0, 16'o000007, 0, q, v);
    chk("xchg_rvalid", 16'(v), 16'd1);
    chk("xchg_old", q, W1);
    op(1'b1, 1'b0, 12'o0200, 3'd0, 16'd0, 0, q, v);
    chk("xchg_new", q, W7);

    // Address error.
    issue(1'b1, 1'b0, 12'o2000, 3'd0, 16'd0);
    chk("aerr_pulse", 16'(adderr0), 16'd1);
    chk("aerr_busy", 16'(busy0), 16'd0);
    tick();
    chk("aerr_one_cycle", 16'(adderr0), 16'd0);
    chk("aerr_no_rvalid", 16'(rvalid0), 16'd0);
    chk("aerr_still_idle", 16'(busy0), 16'd0);

    // Overrun: a write arrives while a read is in SENSE.
    issue(1'b1, 1'b0, 12'o0100, 3'd0, 16'd0);
    rd = 1'b0; wr = 1'b1; s = 12'o0100; wd = 16'o070707;
    tick();
    wr = 1'b0;
    chk("drop_set", 16'(drop0), 16'd1);
    chk("drop_rd_data", rdata0, W3);
    tick();
    op(1'b1, 1'b0, 12'o0100, 3'd0, 16'd0, 0, q, v);
    chk("drop_array_kept", q, W3);
    chk("drop_sticky", 16'(drop0), 16'd1);

`ifdef ERASABLE_PARITY_EN
    // Even-parity word planted directly in the array.
    dut0.mem[11'd192] = 16'o000003;
    op(1'b1, 1'b0, 12'o0300, 3'd0, 16'd0, 0, q, v);
    chk("par_data_unmod", q, 16'o000003);
    chk("par_alarm", 16'(paralm0), 16'd1);
    tick(); tick();
    chk("par_sticky", 16'(paralm0), 16'd1);
    rst0 = 1'b1;
    #1;
    chk("par_rst_clear", 16'(paralm0), 16'd0);
`else
    chk("par_tied_low", 16'(paralm0), 16'd0);
    rst0 = 1'b1;
`endif

    // ---------------- dut3, SENSE_WAIT = 3 ----------------
    tick();
    rst3 = 1'b0;
    op(1'b0, 1'b1, 12'o0040, 3'd0, 16'o000005, 3, q, v);
    issue(1'b1, 1'b0, 12'o0040, 3'd0, 16'd0);
    tick(); tick(); tick();
    chk("sw3_lat_early", 16'(rvalid3), 16'd0);
    tick();
    chk("sw3_lat_rvalid", 16'(rvalid3), 16'd1);
    chk("sw3_data", rdata3, W5);
    tick();

    // Reset in the middle of SENSE.
    issue(1'b1, 1'b0, 12'o0040, 3'd0, 16'd0);
    tick();
    chk("mid_busy", 16'(busy3), 16'd1);
    rst3 = 1'b1;
    #1;
    chk("mid_rst_rdata", rdata3, 16'd0);
    chk("mid_rst_busy", 16'(busy3), 16'd0);
    chk("mid_rst_rvalid", 16'(rvalid3), 16'd0);
    tick();
    rst3 = 1'b0;
    op(1'b1, 1'b0, 12'o0040, 3'd0, 16'd0, 3, q, v);
    chk("mid_rst_rvalid_after", 16'(v), 16'd1);
    chk("mid_rst_word_kept", q, W5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
